// File: rtl/msx2_ram_bridge.sv
// msx2_ram_bridge: turns Z80 memory cycles aimed at mapped RAM into
// single-beat req/ack transactions toward the SDRAM controller. The CPU is
// held with cpu_wait until the controller acknowledges. Accesses that never
// complete are abandoned after TIMEOUT wait cycles and flagged in a sticky bit.
module msx2_ram_bridge #(
  parameter logic [24:0] RAM_BASE = 25'h0000000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_mreq,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  input  logic        ram_sel,
  input  logic [21:0] mapper_addr,
  output logic        cpu_wait,
  output logic [7:0]  cpu_din,
  output logic [24:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        ram_req,
  input  logic        ram_ack,
  input  logic [7:0]  ram_dout,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ram_req_q, ram_req_d;
  logic        ram_we_q, ram_we_d;
  logic [24:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_din_q, ram_din_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        timeout_err_q, timeout_err_d;

  logic        acc_s;
  logic        start_s;
  logic [7:0]  cnt_inc_s;

  // Access qualifier, rising-edge start detect and the wait-counter increment.
  always_comb begin
    acc_s     = cpu_mreq & ram_sel & (cpu_rd | cpu_wr);
    start_s   = acc_s & ~acc_q & (state_q == S_IDLE);
    cnt_inc_s = cnt_q + 8'd1;
  end

  // Next-state and next-register computation for the transaction sequencer.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_s;
    cnt_d         = cnt_q;
    ram_req_d     = 1'b0;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    rd_data_d     = rd_data_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          // Address wraps modulo 2^25; a write strobe wins over a read strobe.
          ram_addr_d = RAM_BASE + {3'b000, mapper_addr};
          ram_din_d  = cpu_dout;
          ram_we_d   = cpu_wr;
          ram_req_d  = 1'b1;
          state_d    = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_REQ: begin
        cnt_d = 8'd0;
        // An ack coinciding with the request cycle already completes it.
        if (ram_ack) begin
          if (!ram_we_q) begin
            rd_data_d = ram_dout;
          end else begin
            rd_data_d = rd_data_q;
          end
          state_d = acc_s ? S_DONE : S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_inc_s;
        // Ack wins over timeout when both land in the same cycle.
        if (ram_ack) begin
          if (!ram_we_q) begin
            rd_data_d = ram_dout;
          end else begin
            rd_data_d = rd_data_q;
          end
          state_d = acc_s ? S_DONE : S_IDLE;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          rd_data_d     = 8'hFF;
          timeout_err_d = 1'b1;
          state_d       = acc_s ? S_DONE : S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_DONE: begin
        // Stay here until the CPU ends its cycle so one access gives one request.
        if (!acc_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      acc_q         <= 1'b0;
      cnt_q         <= 8'd0;
      ram_req_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= 25'd0;
      ram_din_q     <= 8'd0;
      rd_data_q     <= 8'hFF;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      ram_req_q     <= ram_req_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      rd_data_q     <= rd_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Wait asserts in the very cycle the access appears so no sample is missed;
  // read data is driven only while a completed read is still strobed, else
  // 8'hFF so slot buses can be wired-AND.
  assign cpu_wait    = start_s | (state_q == S_REQ) | (state_q == S_WAIT);
  assign cpu_din     = ((state_q == S_DONE) & cpu_rd & ~ram_we_q) ? rd_data_q : 8'hFF;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;
  assign ram_req     = ram_req_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_msx2_ram_bridge.sv
// Directed testbench for msx2_ram_bridge. Three instances with different
// RAM_BASE values share one stimulus bus; TIMEOUT is 4 on all of them.
module tb_msx2_ram_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_mreq, cpu_rd, cpu_wr, ram_sel, ram_ack;
  logic [7:0]  cpu_dout, ram_dout;
  logic [21:0] mapper_addr;

  logic        a_cpu_wait, b_cpu_wait, c_cpu_wait;
  logic [7:0]  a_cpu_din, b_cpu_din, c_cpu_din;
  logic [24:0] a_ram_addr, b_ram_addr, c_ram_addr;
  logic [7:0]  a_ram_din, b_ram_din, c_ram_din;
  logic        a_ram_we, b_ram_we, c_ram_we;
  logic        a_ram_req, b_ram_req, c_ram_req;
  logic        a_timeout_err, b_timeout_err, c_timeout_err;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int wait_cnt = 0;
  int r0;
  int w0;

  always #5 clk = ~clk;

  msx2_ram_bridge #(.RAM_BASE(25'h0000000), .TIMEOUT(4)) u_a (
    .clk(clk), .reset_n(reset_n), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .ram_sel(ram_sel),
    .mapper_addr(mapper_addr), .cpu_wait(a_cpu_wait), .cpu_din(a_cpu_din),
    .ram_addr(a_ram_addr), .ram_din(a_ram_din), .ram_we(a_ram_we),
    .ram_req(a_ram_req), .ram_ack(ram_ack), .ram_dout(ram_dout),
    .timeout_err(a_timeout_err)
  );

  msx2_ram_bridge #(.RAM_BASE(25'h1000000), .TIMEOUT(4)) u_b (
    .clk(clk), .reset_n(reset_n), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .ram_sel(ram_sel),
    .mapper_addr(mapper_addr), .cpu_wait(b_cpu_wait), .cpu_din(b_cpu_din),
    .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_we(b_ram_we),
    .ram_req(b_ram_req), .ram_ack(ram_ack), .ram_dout(ram_dout),
    .timeout_err(b_timeout_err)
  );

  msx2_ram_bridge #(.RAM_BASE(25'h1FFFFFF), .TIMEOUT(4)) u_c (
    .clk(clk), .reset_n(reset_n), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .ram_sel(ram_sel),
    .mapper_addr(mapper_addr), .cpu_wait(c_cpu_wait), .cpu_din(c_cpu_din),
    .ram_addr(c_ram_addr), .ram_din(c_ram_din), .ram_we(c_ram_we),
    .ram_req(c_ram_req), .ram_ack(ram_ack), .ram_dout(ram_dout),
    .timeout_err(c_timeout_err)
  );

  // Free-running tallies of request pulses and wait cycles on instance A.
  always @(negedge clk) begin
    if (a_ram_req) req_cnt <= req_cnt + 1;
    if (a_cpu_wait) wait_cnt <= wait_cnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cpu_mreq = 1'b0;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
    ram_sel  = 1'b0;
  endtask

  task automatic start_acc(input logic [21:0] addr, input logic rd, input logic wr,
                           input logic [7:0] dout);
    mapper_addr = addr;
    cpu_dout    = dout;
    cpu_mreq    = 1'b1;
    ram_sel     = 1'b1;
    cpu_rd      = rd;
    cpu_wr      = wr;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_bus();
    ram_ack = 1'b0;
    ram_dout = 8'h00;
    mapper_addr = 22'h0;
    cpu_dout = 8'h00;
    step();
    step();
    #1;
    chk_eq("rst_wait", 32'(a_cpu_wait), 32'd0);
    chk_eq("rst_din", 32'(a_cpu_din), 32'hFF);
    chk_eq("rst_req", 32'(a_ram_req), 32'd0);
    chk_eq("rst_addr", 32'(a_ram_addr), 32'd0);
    chk_eq("rst_we_din", {23'd0, a_ram_we, a_ram_din}, 32'd0);
    chk_eq("rst_terr", 32'(a_timeout_err), 32'd0);
    reset_n = 1'b1;
    step();

    // Read with ack three cycles after the request.
    r0 = req_cnt;
    w0 = wait_cnt;
    start_acc(22'h012345, 1'b1, 1'b0, 8'h00);
    #1;
    chk_eq("rd_wait_start", 32'(a_cpu_wait), 32'd1);
    step();
    chk_eq("rd_req", 32'(a_ram_req), 32'd1);
    chk_eq("rd_addr", 32'(a_ram_addr), 32'h0012345);
    chk_eq("rd_we", 32'(a_ram_we), 32'd0);
    step();
    chk_eq("rd_req_pulse", 32'(a_ram_req), 32'd0);
    chk_eq("rd_din_busy", 32'(a_cpu_din), 32'hFF);
    step();
    step();
    ram_ack = 1'b1;
    ram_dout = 8'hA5;
    step();
    ram_ack = 1'b0;
    chk_eq("rd_wait_rel", 32'(a_cpu_wait), 32'd0);
    chk_eq("rd_data", 32'(a_cpu_din), 32'hA5);
    repeat (6) step();
    chk_eq("rd_data_hold", 32'(a_cpu_din), 32'hA5);
    chk_eq("rd_one_req", 32'(req_cnt - r0), 32'd1);
    chk_eq("rd_wait_len", 32'(wait_cnt - w0), 32'd5);
    idle_bus();
    #1;
    chk_eq("rd_din_drop", 32'(a_cpu_din), 32'hFF);
    step();

    // Write (both strobes high: write wins) on the high-base instance.
    start_acc(22'h3FFFFF, 1'b1, 1'b1, 8'h5A);
    #1;
    chk_eq("wr_wait_start", 32'(b_cpu_wait), 32'd1);
    step();
    chk_eq("wr_addr", 32'(b_ram_addr), 32'h13FFFFF);
    chk_eq("wr_din", 32'(b_ram_din), 32'h5A);
    chk_eq("wr_we", 32'(b_ram_we), 32'd1);
    chk_eq("wr_cpu_din_req", 32'(b_cpu_din), 32'hFF);
    step();
    ram_ack = 1'b1;
    ram_dout = 8'h42;
    step();
    ram_ack = 1'b0;
    chk_eq("wr_wait_rel", 32'(b_cpu_wait), 32'd0);
    chk_eq("wr_cpu_din_done", 32'(b_cpu_din), 32'hFF);
    idle_bus();
    step();

    // Address wrap, with ack arriving in the request cycle itself.
    start_acc(22'h000002, 1'b1, 1'b0, 8'h00);
    #1;
    step();
    chk_eq("wrap_addr", 32'(c_ram_addr), 32'h0000001);
    ram_ack = 1'b1;
    ram_dout = 8'h3C;
    step();
    ram_ack = 1'b0;
    chk_eq("reqack_wait", 32'(c_cpu_wait), 32'd0);
    chk_eq("reqack_data", 32'(c_cpu_din), 32'h3C);
    idle_bus();
    step();
    chk_eq("wrap_addr_hold", 32'(c_ram_addr), 32'h0000001);

    // Timeout: no ack, TIMEOUT = 4 wait cycles.
    w0 = wait_cnt;
    start_acc(22'h000100, 1'b1, 1'b0, 8'h00);
    step();
    step();
    step();
    step();
    step();
    chk_eq("to_wait_last", 32'(a_cpu_wait), 32'd1);
    chk_eq("to_err_early", 32'(a_timeout_err), 32'd0);
    step();
    chk_eq("to_wait_rel", 32'(a_cpu_wait), 32'd0);
    chk_eq("to_err", 32'(a_timeout_err), 32'd1);
    chk_eq("to_din", 32'(a_cpu_din), 32'hFF);
    chk_eq("to_wait_len", 32'(wait_cnt - w0), 32'd6);
    idle_bus();
    step();

    // Successful access after a timeout keeps the sticky flag.
    start_acc(22'h000200, 1'b1, 1'b0, 8'h00);
    step();
    ram_ack = 1'b1;
    ram_dout = 8'h11;
    step();
    ram_ack = 1'b0;
    chk_eq("sticky_data", 32'(a_cpu_din), 32'h11);
    chk_eq("sticky_err", 32'(a_timeout_err), 32'd1);
    idle_bus();
    step();

    // Early release: strobe drops during WAIT, then the ack arrives.
    r0 = req_cnt;
    start_acc(22'h000300, 1'b1, 1'b0, 8'h00);
    step();
    step();
    idle_bus();
    step();
    ram_ack = 1'b1;
    ram_dout = 8'h77;
    step();
    ram_ack = 1'b0;
    cpu_rd = 1'b1;
    #1;
    chk_eq("early_din", 32'(a_cpu_din), 32'hFF);
    chk_eq("early_wait", 32'(a_cpu_wait), 32'd0);
    chk_eq("early_one_req", 32'(req_cnt - r0), 32'd1);
    cpu_rd = 1'b0;
    step();

    // Reset in the middle of WAIT, then a stray ack.
    start_acc(22'h000400, 1'b1, 1'b0, 8'h00);
    step();
    step();
    reset_n = 1'b0;
    idle_bus();
    #1;
    chk_eq("mid_rst_wait", 32'(a_cpu_wait), 32'd0);
    r0 = req_cnt;
    step();
    reset_n = 1'b1;
    step();
    ram_ack = 1'b1;
    ram_dout = 8'h99;
    step();
    ram_ack = 1'b0;
    chk_eq("post_rst_wait", 32'(a_cpu_wait), 32'd0);
    chk_eq("post_rst_err", 32'(a_timeout_err), 32'd0);
    chk_eq("post_rst_din", 32'(a_cpu_din), 32'hFF);
    step();
    chk_eq("post_rst_noreq", 32'(req_cnt - r0), 32'd0);

    // Normal read after the reset.
    start_acc(22'h000500, 1'b1, 1'b0, 8'h00);
    step();
    chk_eq("rerd_addr", 32'(a_ram_addr), 32'h0000500);
    chk_eq("rerd_req", 32'(a_ram_req), 32'd1);
    step();
    ram_ack = 1'b1;
    ram_dout = 8'hC3;
    step();
    ram_ack = 1'b0;
    chk_eq("rerd_data", 32'(a_cpu_din), 32'hC3);
    idle_bus();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msx2_ram_bridge.md
Name: msx2_ram_bridge

Overview:
- Consumes the 22-bit physical address from the MSX2 RAM mapper and turns Z80 memory reads/writes into single-beat request/acknowledge transactions toward the SDRAM controller.
- Holds the CPU with a wait signal until the controller acknowledges the transaction.
- Returns the latched read byte to the CPU data bus.
- Flags accesses the controller never acknowledges.

Parameters:
- RAM_BASE, 25'h0000000, SDRAM byte offset of the mapped-RAM region; added to the mapper address.
- TIMEOUT, 255, number of WAIT-state cycles without acknowledge before the access is abandoned; range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- cpu_mreq  input  1  Z80 memory request
- cpu_rd  input  1  Z80 read strobe
- cpu_wr  input  1  Z80 write strobe
- cpu_dout  input  8  CPU write data
- ram_sel  input  1  slot decode: the current address targets mapped RAM
- mapper_addr  input  22  physical address from the RAM mapper
- cpu_wait  output  1  wait request to the CPU
- cpu_din  output  8  read data to the CPU bus; 8'hFF when not driving
- ram_addr  output  25  SDRAM byte address
- ram_din  output  8  SDRAM write data
- ram_we  output  1  1 = write transaction, 0 = read transaction
- ram_req  output  1  single-cycle request pulse to the SDRAM controller
- ram_ack  input  1  single-cycle completion pulse from the SDRAM controller
- ram_dout  input  8  SDRAM read data; valid in the ram_ack cycle
- timeout_err  output  1  sticky flag: at least one access timed out

Behaviour:
- Access qualifier: acc = cpu_mreq & ram_sel & (cpu_rd | cpu_wr).
- Start condition: start = acc & ~acc_q & (state==IDLE). acc_q is acc registered on each clk edge.
- States: IDLE, REQ, WAIT, DONE. Encoding is free.
- IDLE:
  - On start, register ram_addr = RAM_BASE + {3'b0, mapper_addr}, computed as a 25-bit sum that wraps modulo 2^25.
  - Register ram_din = cpu_dout and ram_we = cpu_wr. cpu_wr takes priority if both strobes are high.
  - Next state: REQ.
- REQ:
  - ram_req = 1 for exactly this cycle.
  - Clear the timeout counter.
  - Next state: WAIT. If ram_ack is already high in this cycle, treat it as completion; see WAIT.
- WAIT:
  - The counter increments each cycle.
  - On ram_ack: if ~ram_we, latch rd_data = ram_dout. Next state is DONE if acc is still high, else IDLE.
  - If the counter equals TIMEOUT with no ack: set rd_data = 8'hFF and set timeout_err. Next state follows the same acc rule as the ack case.
  - ram_ack has priority over timeout in the same cycle.
- DONE:
  - Hold until acc == 0, then go to IDLE.
  - A new start cannot be recognised until acc has returned low, which is guaranteed by the edge detect.
- cpu_wait is combinational: cpu_wait = start | (state==REQ) | (state==WAIT). It goes high in the same cycle the access is seen, so no CPU wait-sample window is missed.
- cpu_din = rd_data when (state==DONE) & cpu_rd & ~ram_we; otherwise 8'hFF, so the slot data buses can be wired-AND.
- ram_ack arriving in IDLE or DONE is ignored.
- ram_addr, ram_din and ram_we stay stable from the IDLE->REQ edge until the next start.
- timeout_err clears only on reset.
- Reset (reset_n low, asynchronous):
  - State = IDLE, acc_q = 0, counter = 0.
  - ram_req = 0, ram_we = 0, ram_addr = 0, ram_din = 0.
  - rd_data = 8'hFF, timeout_err = 0.
  - Resulting outputs: cpu_wait = 0, cpu_din = 8'hFF.
  - Reset mid-transaction abandons it with no further ram_req; a late ram_ack after reset is ignored.
- Latency: the first ram_req occurs 1 clk after the start cycle. cpu_wait falls in the cycle after ram_ack is sampled.

Test Plan:
- Read, RAM_BASE=0: mapper_addr=22'h01_2345, cpu_rd pulse, ram_ack 3 cycles after ram_req with ram_dout=8'hA5 -> ram_addr=25'h0012345, ram_we=0, one ram_req pulse, cpu_wait high 5 cycles, cpu_din=8'hA5 until cpu_rd drops, then 8'hFF.
- Write, RAM_BASE=25'h1000000: mapper_addr=22'h3F_FFFF, cpu_dout=8'h5A -> ram_addr=25'h13FFFFF, ram_din=8'h5A, ram_we=1; cpu_din stays 8'hFF throughout.
- Wrap: RAM_BASE=25'h1FFFFFF, mapper_addr=22'h000002 -> ram_addr=25'h0000001.
- Timeout, TIMEOUT=4, ram_ack never asserted -> cpu_wait releases after 4 WAIT cycles, cpu_din=8'hFF, timeout_err=1 and stays 1 across the next successful access.
- Early release: cpu_rd dropped while in WAIT, then ram_ack -> state goes directly to IDLE, cpu_din stays 8'hFF. A long-held cpu_rd produces exactly one ram_req.
- Reset mid-WAIT: reset_n low for 1 cycle, then a stray ram_ack -> cpu_wait=0, no ram_req, timeout_err=0, state IDLE. The next read completes normally.
